// File: rtl/osc_cmd_bank.sv
// Oscillator bank command decoder: opcoded writes land in shadow registers; COMMIT copies them to the active outputs.
// Latency: shadow/active updates and readback load on the accepting edge; cmd_err is registered and asserts one cycle after it.
// Backpressure: cmd_ready = !rd_valid || rd_ready, so commands stall while a readback is held unconsumed.
//
// Ports:
//   sys_clk, sys_rst           clock, asynchronous active-high reset
//   cmd_word/data_word         [7:5] opcode, [4:0] channel; payload
//   cmd_valid/cmd_ready        command handshake
//   rd_data/rd_valid/rd_ready  readback handshake, data zero-extended
//   cmd_err                    one-cycle pulse after a rejected command
//   dirty                      shadow written since last commit
//   osc_en/tune/wave/pw        active per-channel outputs, channel i at [i*W +: W]
//   mode_sel                   active global mode
module osc_cmd_bank #(
    parameter int NUM_OSC          = 2,
    parameter int DATAWORD_WIDTH   = 16,
    parameter int TUNING_WIDTH     = 14,
    parameter int WAVE_SEL_WIDTH   = 3,
    parameter int PULSEWIDTH_WIDTH = 12,
    parameter int MODE_SEL_WIDTH   = 2,
    parameter int AUTO_COMMIT      = 0
) (
    input  logic                                 sys_clk,
    input  logic                                 sys_rst,
    input  logic [7:0]                           cmd_word,
    input  logic [DATAWORD_WIDTH-1:0]            data_word,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    output logic [DATAWORD_WIDTH-1:0]            rd_data,
    output logic                                 rd_valid,
    input  logic                                 rd_ready,
    output logic                                 cmd_err,
    output logic                                 dirty,
    output logic [NUM_OSC-1:0]                   osc_en,
    output logic [NUM_OSC*TUNING_WIDTH-1:0]      osc_tune,
    output logic [NUM_OSC*WAVE_SEL_WIDTH-1:0]    osc_wave,
    output logic [NUM_OSC*PULSEWIDTH_WIDTH-1:0]  osc_pw,
    output logic [MODE_SEL_WIDTH-1:0]            mode_sel
);

    localparam int CHW = (NUM_OSC > 1) ? $clog2(NUM_OSC) : 1;
    localparam logic [5:0] NUM_OSC_W = 6'(NUM_OSC);

    typedef enum logic [2:0] {
        OP_NOP, OP_TUNE, OP_WAVE, OP_PW, OP_EN, OP_MODE, OP_COMMIT, OP_READ
    } op_e;

    localparam logic AUTO = (AUTO_COMMIT != 0);

    logic [TUNING_WIDTH-1:0]     tune_sh_q [NUM_OSC], tune_sh_d [NUM_OSC];
    logic [TUNING_WIDTH-1:0]     tune_ac_q [NUM_OSC], tune_ac_d [NUM_OSC];
    logic [WAVE_SEL_WIDTH-1:0]   wave_sh_q [NUM_OSC], wave_sh_d [NUM_OSC];
    logic [WAVE_SEL_WIDTH-1:0]   wave_ac_q [NUM_OSC], wave_ac_d [NUM_OSC];
    logic [PULSEWIDTH_WIDTH-1:0] pw_sh_q   [NUM_OSC], pw_sh_d   [NUM_OSC];
    logic [PULSEWIDTH_WIDTH-1:0] pw_ac_q   [NUM_OSC], pw_ac_d   [NUM_OSC];
    logic [NUM_OSC-1:0]          en_sh_q, en_sh_d, en_ac_q, en_ac_d;
    logic [MODE_SEL_WIDTH-1:0]   mode_sh_q, mode_sh_d, mode_ac_q, mode_ac_d;
    logic                        dirty_q, dirty_d;
    logic                        rd_valid_q, rd_valid_d;
    logic [DATAWORD_WIDTH-1:0]   rd_data_q, rd_data_d, rd_val;
    logic                        cmd_err_q;

    op_e                         op;
    logic [4:0]                  ch;
    logic [CHW-1:0]              ch_sel;
    logic [2:0]                  field;
    logic                        use_sh, ch_ok, chan_op, err, accept, do_cmd, is_write;

    assign op     = op_e'(cmd_word[7:5]);
    assign ch     = cmd_word[4:0];
    assign ch_sel = ch[CHW-1:0];
    assign field  = data_word[2:0];
    assign use_sh = data_word[3];
    assign ch_ok  = ({1'b0, ch} < NUM_OSC_W);

    assign cmd_ready = !rd_valid_q || rd_ready;
    assign accept    = cmd_valid && cmd_ready;

    // Channel-scoped: per-channel writes, and READs of per-channel fields.
    assign chan_op  = (op inside {OP_TUNE, OP_WAVE, OP_PW, OP_EN}) ||
                      (op == OP_READ && field <= 3'd3);
    assign err      = accept && ((chan_op && !ch_ok) || (op == OP_READ && field > 3'd4));
    assign do_cmd   = accept && !err;
    assign is_write = op inside {OP_TUNE, OP_WAVE, OP_PW, OP_EN, OP_MODE};

    // Readback mux; ch_sel is only meaningful when err is clear.
    always_comb begin
        rd_val = '0;
        case (field)
            3'd0: rd_val[TUNING_WIDTH-1:0]     = use_sh ? tune_sh_q[ch_sel] : tune_ac_q[ch_sel];
            3'd1: rd_val[WAVE_SEL_WIDTH-1:0]   = use_sh ? wave_sh_q[ch_sel] : wave_ac_q[ch_sel];
            3'd2: rd_val[PULSEWIDTH_WIDTH-1:0] = use_sh ? pw_sh_q[ch_sel]   : pw_ac_q[ch_sel];
            3'd3: rd_val[0]                    = use_sh ? en_sh_q[ch_sel]   : en_ac_q[ch_sel];
            3'd4: rd_val[MODE_SEL_WIDTH-1:0]   = use_sh ? mode_sh_q         : mode_ac_q;
            default: rd_val = '0;
        endcase
    end

    always_comb begin
        tune_sh_d = tune_sh_q;  tune_ac_d = tune_ac_q;
        wave_sh_d = wave_sh_q;  wave_ac_d = wave_ac_q;
        pw_sh_d   = pw_sh_q;    pw_ac_d   = pw_ac_q;
        en_sh_d   = en_sh_q;    en_ac_d   = en_ac_q;
        mode_sh_d = mode_sh_q;  mode_ac_d = mode_ac_q;
        dirty_d    = dirty_q;
        rd_valid_d = rd_valid_q && !rd_ready;
        rd_data_d  = rd_data_q;
        if (do_cmd) begin
            case (op)
                OP_TUNE: begin
                    tune_sh_d[ch_sel] = data_word[TUNING_WIDTH-1:0];
                    if (AUTO) tune_ac_d[ch_sel] = data_word[TUNING_WIDTH-1:0];
                end
                OP_WAVE: begin
                    wave_sh_d[ch_sel] = data_word[WAVE_SEL_WIDTH-1:0];
                    if (AUTO) wave_ac_d[ch_sel] = data_word[WAVE_SEL_WIDTH-1:0];
                end
                OP_PW: begin
                    pw_sh_d[ch_sel] = data_word[PULSEWIDTH_WIDTH-1:0];
                    if (AUTO) pw_ac_d[ch_sel] = data_word[PULSEWIDTH_WIDTH-1:0];
                end
                OP_EN: begin
                    en_sh_d[ch_sel] = data_word[0];
                    if (AUTO) en_ac_d[ch_sel] = data_word[0];
                end
                OP_MODE: begin
                    mode_sh_d = data_word[MODE_SEL_WIDTH-1:0];
                    if (AUTO) mode_ac_d = data_word[MODE_SEL_WIDTH-1:0];
                end
                OP_COMMIT: begin
                    // In auto-commit mode active already tracks shadow.
                    if (!AUTO) begin
                        tune_ac_d = tune_sh_q;
                        wave_ac_d = wave_sh_q;
                        pw_ac_d   = pw_sh_q;
                        en_ac_d   = en_sh_q;
                        mode_ac_d = mode_sh_q;
                        dirty_d   = 1'b0;
                    end
                end
                OP_READ: begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = rd_val;
                end
                default: ;
            endcase
            if (is_write && !AUTO) dirty_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tune_sh_q  <= '{default: '0};
            tune_ac_q  <= '{default: '0};
            wave_sh_q  <= '{default: '0};
            wave_ac_q  <= '{default: '0};
            pw_sh_q    <= '{default: '0};
            pw_ac_q    <= '{default: '0};
            en_sh_q    <= '0;
            en_ac_q    <= '0;
            mode_sh_q  <= '0;
            mode_ac_q  <= '0;
            dirty_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            cmd_err_q  <= 1'b0;
        end else begin
            tune_sh_q  <= tune_sh_d;
            tune_ac_q  <= tune_ac_d;
            wave_sh_q  <= wave_sh_d;
            wave_ac_q  <= wave_ac_d;
            pw_sh_q    <= pw_sh_d;
            pw_ac_q    <= pw_ac_d;
            en_sh_q    <= en_sh_d;
            en_ac_q    <= en_ac_d;
            mode_sh_q  <= mode_sh_d;
            mode_ac_q  <= mode_ac_d;
            dirty_q    <= dirty_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            cmd_err_q  <= err;
        end
    end

    for (genvar i = 0; i < NUM_OSC; i++) begin : g_pack
        assign osc_tune[i*TUNING_WIDTH +: TUNING_WIDTH]         = tune_ac_q[i];
        assign osc_wave[i*WAVE_SEL_WIDTH +: WAVE_SEL_WIDTH]     = wave_ac_q[i];
        assign osc_pw[i*PULSEWIDTH_WIDTH +: PULSEWIDTH_WIDTH]   = pw_ac_q[i];
    end

    assign osc_en   = en_ac_q;
    assign mode_sel = mode_ac_q;
    assign dirty    = dirty_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: doc/osc_cmd_bank.md
Name: osc_cmd_bank

Overview:
- Parametrised successor to the SPI command decoder; sits between the SPI slave and the oscillator bank.
- Supports NUM_OSC oscillator channels, each with its own tuning word, waveform, pulse width and enable, plus a global mode select.
- Writes from opcoded commands land in shadow registers. A COMMIT command (or AUTO_COMMIT) copies them to the active outputs atomically.
- Adds register readback with a valid/ready handshake, and error flagging.

Parameters:
NUM_OSC, 2, number of oscillator channels (1..32)
DATAWORD_WIDTH, 16, SPI data field width
TUNING_WIDTH, 14, tuning word width per channel (<= DATAWORD_WIDTH)
WAVE_SEL_WIDTH, 3, waveform select width per channel
PULSEWIDTH_WIDTH, 12, pulse width per channel
MODE_SEL_WIDTH, 2, global modulation select width
AUTO_COMMIT, 0, 1 = writes update shadow and active in the same edge

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous active-high reset
cmd_word  in  8  [7:5] opcode, [4:0] channel index
data_word  in  DATAWORD_WIDTH  command payload
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at sys_clk edge
rd_data  out  DATAWORD_WIDTH  readback value, zero-extended
rd_valid  out  1  readback available
rd_ready  in  1  consumer accepts readback
cmd_err  out  1  one-cycle pulse on rejected command
dirty  out  1  shadow differs from active (write since last commit)
osc_en  out  NUM_OSC  active enables, bit i = channel i
osc_tune  out  NUM_OSC*TUNING_WIDTH  active tuning words, channel i at [i*TUNING_WIDTH +: TUNING_WIDTH]
osc_wave  out  NUM_OSC*WAVE_SEL_WIDTH  active waveform selects, same packing
osc_pw  out  NUM_OSC*PULSEWIDTH_WIDTH  active pulse widths, same packing
mode_sel  out  MODE_SEL_WIDTH  active global mode

Behaviour:
- Reset (async, sys_rst high): all shadow and active registers 0, rd_valid 0, rd_data 0, cmd_err 0, dirty 0, cmd_ready 1.
- Accept = cmd_valid && cmd_ready. Nothing happens without accept.
- Opcodes:
  - 0 NOP: no effect.
  - 1 SET_TUNE: shadow tune[ch] <= data[TUNING_WIDTH-1:0].
  - 2 SET_WAVE: shadow wave[ch] <= low WAVE_SEL_WIDTH bits of data.
  - 3 SET_PW: shadow pw[ch] <= low PULSEWIDTH_WIDTH bits of data.
  - 4 SET_EN: shadow en[ch] <= data[0].
  - 5 SET_MODE: shadow mode <= low MODE_SEL_WIDTH bits of data; channel field ignored.
  - 6 COMMIT: all active <= all shadow; channel field ignored.
  - 7 READ: field = data[2:0] (0 tune, 1 wave, 2 pw, 3 en, 4 mode); data[3] = 1 reads shadow, 0 reads active.
- Latency: shadow registers update on the accepting edge, so the new value is visible the next cycle. COMMIT updates the active outputs on the accepting edge.
- With AUTO_COMMIT=1, every write updates the active register on the same edge; COMMIT behaves as NOP and dirty stays 0.
- dirty: set on any accepted write opcode (1-5) when AUTO_COMMIT=0; cleared by COMMIT. A write and the commit cannot coincide, because only one command is accepted per cycle.
- Errors: the command is ignored and cmd_err is high for exactly the cycle after the accepting edge when either of these holds:
  - A channel-scoped opcode (1-4, or READ of fields 0-3) has ch >= NUM_OSC.
  - A READ has field 5-7.
- Readback: an accepted READ sets rd_valid and loads rd_data at the accepting edge. rd_data is zero-extended and stable while rd_valid is high.
  - rd_valid clears on the edge where rd_valid && rd_ready.
  - cmd_ready = !rd_valid || rd_ready, so commands stall while a readback is unconsumed. A back-to-back READ in the handshake cycle reloads rd_valid/rd_data and rd_valid stays high.
- A readback of the active registers in the COMMIT cycle is impossible (single accept per cycle). A READ after COMMIT returns the committed value.
- Reset asserted mid-readback: rd_valid drops immediately (async); pending data is lost.

Test Plan:
- Reset, then write SET_TUNE ch1 = 0x1234 (TUNING 14b) -> shadow holds 0x1234, osc_tune ch1 stays 0, dirty=1. Then COMMIT -> osc_tune[27:14]=0x1234 next cycle, dirty=0.
- SET_EN ch0=1, SET_WAVE ch0=5, SET_MODE=2, then COMMIT -> osc_en=2'b01, osc_wave[2:0]=5 and mode_sel=2 all change on the same edge.
- SET_PW ch5 with NUM_OSC=2 -> cmd_err pulses for 1 cycle, no state change; READ field 6 -> cmd_err, rd_valid stays 0.
- After tune ch1 = 0x1234 has been written but not committed:
  - READ tune ch1 shadow (data=0x0008) with rd_ready=0 -> rd_valid=1, rd_data=0x1234, cmd_ready=0 for 5 cycles.
  - Raise rd_ready -> rd_valid clears and cmd_ready=1.
  - READ active of the same field -> 0x0000.
- AUTO_COMMIT=1: SET_TUNE ch0=0x3FFF -> osc_tune ch0=0x3FFF next cycle, dirty=0.
- Assert sys_rst while rd_valid=1 and osc_en=2'b11 -> all outputs 0 immediately, cmd_ready=1.
